// File: rtl/edge_seq_pkg.sv
// Shared types for the edge_counter_sequencer slice.
// Holds the FSM state enum, the readout word selector and default widths.
package edge_seq_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    SNAP    = 3'd3,
    READOUT = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    SEL_D1 = 2'd0,
    SEL_D2 = 2'd1,
    SEL_D3 = 2'd2
  } rd_sel_e;

endpackage

// File: rtl/edge_seq_rd_if.sv
// Readout stream: valid/ready word port with channel, selector and last flag.
// master drives valid/data/ch/sel/last and samples ready; slave is the consumer.
interface edge_seq_rd_if
  import edge_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int CH_W  = 2
);

  logic             valid;
  logic             ready;
  logic [CNT_W-1:0] data;
  logic [CH_W-1:0]  ch;
  logic [1:0]       sel;
  logic             last;

  modport master (
    output valid, data, ch, sel, last,
    input  ready
  );

  modport slave (
    input  valid, data, ch, sel, last,
    output ready
  );

endinterface

// File: rtl/edge_seq_readout.sv
// Snapshot registers and valid/ready word walker for the sequencer.
// Ports: clk, rst_n, clr (drop stream), snap (capture), en (channel mask),
//   d1/d2/d3 (packed counts), rd (stream master), fin (last word accepted).
module edge_seq_readout
  import edge_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    snap,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*CNT_W-1:0] d1,
  input  logic [NUM_CH*CNT_W-1:0] d2,
  input  logic [NUM_CH*CNT_W-1:0] d3,
  edge_seq_rd_if.master           rd,
  output logic                    fin
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [CNT_W-1:0] s1_q [NUM_CH];
  logic [CNT_W-1:0] s2_q [NUM_CH];
  logic [CNT_W-1:0] s3_q [NUM_CH];
  logic [CNT_W-1:0] s1_d [NUM_CH];
  logic [CNT_W-1:0] s2_d [NUM_CH];
  logic [CNT_W-1:0] s3_d [NUM_CH];

  logic            valid_q, valid_d;
  logic [CH_W-1:0] ch_q, ch_d;
  rd_sel_e         sel_q, sel_d;

  logic [CH_W-1:0] first_ch, nxt_ch;
  logic            nxt_ok, last, acc;

  // Lowest enabled channel overall and lowest one above the current word.
  always_comb begin
    first_ch = '0;
    nxt_ch   = '0;
    nxt_ok   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (en[i]) first_ch = CH_W'(i);
      if (en[i] && i > int'(ch_q)) begin
        nxt_ch = CH_W'(i);
        nxt_ok = 1'b1;
      end
    end
  end

  assign last = (sel_q == SEL_D3) && !nxt_ok;
  assign acc  = valid_q && rd.ready;
  assign fin  = acc && last;

  always_comb begin
    valid_d = valid_q;
    ch_d    = ch_q;
    sel_d   = sel_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    s3_d    = s3_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (snap) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (en[i]) begin
          s1_d[i] = d1[i*CNT_W +: CNT_W];
          s2_d[i] = d2[i*CNT_W +: CNT_W];
          s3_d[i] = d3[i*CNT_W +: CNT_W];
        end
      end
      valid_d = 1'b1;
      ch_d    = first_ch;
      sel_d   = SEL_D1;
    end else if (acc) begin
      if (sel_q != SEL_D3) begin
        sel_d = rd_sel_e'(sel_q + 2'd1);
      end else if (nxt_ok) begin
        ch_d  = nxt_ch;
        sel_d = SEL_D1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ch_q    <= '0;
      sel_q   <= SEL_D1;
      for (int i = 0; i < NUM_CH; i++) begin
        s1_q[i] <= '0;
        s2_q[i] <= '0;
        s3_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ch_q    <= ch_d;
      sel_q   <= sel_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
    end
  end

  always_comb begin
    rd.data = '0;
    if (valid_q) begin
      unique case (sel_q)
        SEL_D1:  rd.data = s1_q[ch_q];
        SEL_D2:  rd.data = s2_q[ch_q];
        default: rd.data = s3_q[ch_q];
      endcase
    end
  end

  assign rd.valid = valid_q;
  assign rd.ch    = valid_q ? ch_q : '0;
  assign rd.sel   = valid_q ? sel_q : SEL_D1;
  assign rd.last  = valid_q && last;

endmodule

// File: rtl/edge_counter_sequencer.sv
// Run controller for NUM_CH edge_counter channels: arm, trigger broadcast,
// completion/timeout detect, snapshot and valid/ready readout stream.
// Ports: clk, rst_n, start, abort, cfg_* (run config), ch_* (channel side),
//   rd (readout stream master), busy, done, timed_out.
// Optional macro EDGE_SEQ_REARM_EN adds cfg_rearm for continuous capture.
module edge_counter_sequencer
  import edge_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TMO_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NUM_CH-1:0]         cfg_ch_en,
  input  logic [$clog2(NUM_CH)-1:0] cfg_master,
  input  logic [TMO_W-1:0]          cfg_timeout,
`ifdef EDGE_SEQ_REARM_EN
  input  logic                      cfg_rearm,
`endif
  output logic [NUM_CH-1:0]         ch_enable,
  input  logic [NUM_CH-1:0]         ch_trig_out,
  output logic [NUM_CH-1:0]         ch_trig_in,
  input  logic [NUM_CH*CNT_W-1:0]   ch_d1,
  input  logic [NUM_CH*CNT_W-1:0]   ch_d2,
  input  logic [NUM_CH*CNT_W-1:0]   ch_d3,
  edge_seq_rd_if.master             rd,
  output logic                      busy,
  output logic                      done,
  output logic                      timed_out
);

  localparam int CH_W = $clog2(NUM_CH);

  seq_state_e       state_q, state_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [CH_W-1:0]  master_q, master_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] d3_prev_q [NUM_CH];
  logic [CNT_W-1:0] d3_prev_d [NUM_CH];

  logic [NUM_CH-1:0] complete;
  logic              all_done, tmo_hit, fin, rearm;

`ifdef EDGE_SEQ_REARM_EN
  assign rearm = cfg_rearm;
`else
  assign rearm = 1'b0;
`endif

  // A counting d3 moves every cycle; a nonzero value held for a cycle
  // means the channel finished (or saturated).
  always_comb begin
    complete = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      d3_prev_d[i] = ch_d3[i*CNT_W +: CNT_W];
      complete[i]  = (ch_d3[i*CNT_W +: CNT_W] != '0) &&
                     (ch_d3[i*CNT_W +: CNT_W] == d3_prev_q[i]);
    end
  end

  assign all_done = &(complete | ~en_q);
  assign tmo_hit  = (tmo_q != '0) && (cnt_q == tmo_q);

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    master_d = master_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    done_d   = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && (cfg_ch_en != '0)) begin
            en_d     = cfg_ch_en;
            master_d = cfg_master;
            tmo_d    = cfg_timeout;
            to_d     = 1'b0;
            state_d  = CLEAR;
          end
        end
        CLEAR: begin
          cnt_d   = '0;
          state_d = RUN;
        end
        RUN: begin
          if (all_done) begin
            state_d = SNAP;
          end else if (tmo_hit) begin
            state_d = SNAP;
            to_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + TMO_W'(1);
          end
        end
        SNAP: state_d = READOUT;
        READOUT: begin
          if (fin) begin
            done_d  = 1'b1;
            state_d = rearm ? CLEAR : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      en_q     <= '0;
      master_q <= '0;
      tmo_q    <= '0;
      cnt_q    <= '0;
      to_q     <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) d3_prev_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      master_q  <= master_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      done_q    <= done_d;
      d3_prev_q <= d3_prev_d;
    end
  end

  always_comb begin
    ch_enable = '0;
    if (state_q == RUN || state_q == SNAP) ch_enable = en_q;
  end

  always_comb begin
    ch_trig_in = '0;
    if (state_q == RUN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_trig_in[i] = ch_trig_out[master_q] & en_q[i] &
                        (CH_W'(i) != master_q);
      end
    end
  end

  edge_seq_readout #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) u_readout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort),
    .snap  (state_q == SNAP),
    .en    (en_q),
    .d1    (ch_d1),
    .d2    (ch_d2),
    .d3    (ch_d3),
    .rd    (rd),
    .fin   (fin)
  );

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign timed_out = to_q;

endmodule

// File: tb/tb_edge_counter_sequencer.sv
// Self-checking bench for edge_counter_sequencer with behavioural channels
// and a run-level reference model compared on every cycle.
module tb_edge_counter_sequencer;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [N-1:0]   cfg_ch_en = '0;
  logic [1:0]     cfg_master = '0;
  logic [31:0]    cfg_timeout = '0;
`ifdef EDGE_SEQ_REARM_EN
  logic           cfg_rearm = 1'b0;
`endif
  logic [N-1:0]   ch_enable;
  logic [N-1:0]   ch_trig_out = '0;
  logic [N-1:0]   ch_trig_in;
  logic [N*W-1:0] ch_d1, ch_d2, ch_d3;
  logic           busy, done, timed_out;

  edge_seq_rd_if #(.CNT_W(W), .CH_W(2)) rd_if ();

  edge_counter_sequencer #(
    .NUM_CH(N), .CNT_W(W), .TMO_W(32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cfg_ch_en   (cfg_ch_en),
    .cfg_master  (cfg_master),
    .cfg_timeout (cfg_timeout),
`ifdef EDGE_SEQ_REARM_EN
    .cfg_rearm   (cfg_rearm),
`endif
    .ch_enable   (ch_enable),
    .ch_trig_out (ch_trig_out),
    .ch_trig_in  (ch_trig_in),
    .ch_d1       (ch_d1),
    .ch_d2       (ch_d2),
    .ch_d3       (ch_d3),
    .rd          (rd_if),
    .busy        (busy),
    .done        (done),
    .timed_out   (timed_out)
  );

  initial forever #5 clk = ~clk;

  // Behavioural channels: zeroed while disabled, d3 counts up to stop_v.
  int unsigned c_d3 [N];
  int unsigned stop_v [N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!ch_enable[i]) c_d3[i] <= 0;
      else if (c_d3[i] < stop_v[i]) c_d3[i] <= c_d3[i] + 1;
    end
  end

  always_comb begin
    ch_d1 = '0;
    ch_d2 = '0;
    ch_d3 = '0;
    for (int i = 0; i < N; i++) begin
      ch_d1[i*W +: W] = 32'(2 * c_d3[i]);
      ch_d2[i*W +: W] = 32'(3 * c_d3[i] + i);
      ch_d3[i*W +: W] = c_d3[i];
    end
  end

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  ch;
    logic [1:0]  sel;
    logic        last;
  } word_t;

  // Reference model: run phase, latched config and pending words.
  int          m_phase = 0;
  logic [N-1:0] m_en = '0;
  logic [1:0]  m_master = '0;
  int unsigned m_tmo = 0;
  int unsigned m_cnt = 0;
  logic        m_to = 1'b0;
  logic        m_done = 1'b0;
  int unsigned m_prev [N];
  word_t       m_q [$];
  word_t       act_log [$];
  int          done_seen = 0;
  int          vcnt = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_mode = 0;
  int hold = 0;
  bit trig_rand = 1'b0;

  always @(posedge clk) begin
    word_t w;
    logic  all, rearm_now;
    if (rd_if.valid && rd_if.ready)
      act_log.push_back({rd_if.data, rd_if.ch, rd_if.sel, rd_if.last});
    if (rd_if.valid) vcnt++;
    if (done) done_seen++;
`ifdef EDGE_SEQ_REARM_EN
    rearm_now = cfg_rearm;
`else
    rearm_now = 1'b0;
`endif
    if (!rst_n) begin
      m_phase = 0;
      m_to    = 0;
      m_done  = 0;
      m_q.delete();
      for (int i = 0; i < N; i++) m_prev[i] = 0;
    end else begin
      m_done = 0;
      if (abort) begin
        m_phase = 0;
        m_q.delete();
      end else begin
        case (m_phase)
          0: if (start && cfg_ch_en != 0) begin
               m_en = cfg_ch_en;
               m_master = cfg_master;
               m_tmo = cfg_timeout;
               m_to = 0;
               m_phase = 1;
             end
          1: begin m_cnt = 0; m_phase = 2; end
          2: begin
               all = 1;
               for (int i = 0; i < N; i++)
                 if (m_en[i] && !(c_d3[i] != 0 && c_d3[i] == m_prev[i]))
                   all = 0;
               if (all) m_phase = 3;
               else if (m_tmo != 0 && m_cnt == m_tmo) begin
                 m_phase = 3;
                 m_to = 1;
               end else m_cnt++;
             end
          3: begin
               for (int i = 0; i < N; i++) begin
                 if (m_en[i]) begin
                   w = '0;
                   w.ch = 2'(i);
                   w.data = ch_d1[i*W +: W]; w.sel = 0; m_q.push_back(w);
                   w.data = ch_d2[i*W +: W]; w.sel = 1; m_q.push_back(w);
                   w.data = ch_d3[i*W +: W]; w.sel = 2; m_q.push_back(w);
                 end
               end
               m_phase = 4;
             end
          4: if (rd_ready_now()) begin
               void'(m_q.pop_front());
               if (m_q.size() == 0) begin
                 m_done = 1;
                 m_phase = rearm_now ? 1 : 0;
               end
             end
          default: m_phase = 0;
        endcase
      end
      for (int i = 0; i < N; i++) m_prev[i] = c_d3[i];
    end
  end

  function automatic logic rd_ready_now();
    return rd_if.ready;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic [N-1:0] e_en, e_trig;
    e_en = (m_phase == 2 || m_phase == 3) ? m_en : '0;
    e_trig = '0;
    if (m_phase == 2)
      e_trig = {N{ch_trig_out[m_master]}} & m_en & ~(4'b1 << m_master);
    chk("busy", busy, m_phase != 0);
    chk("ch_enable", ch_enable, e_en);
    chk("ch_trig_in", ch_trig_in, e_trig);
    chk("rd_valid", rd_if.valid, m_phase == 4);
    if (m_phase == 4 && m_q.size() > 0) begin
      chk("rd_data", rd_if.data, m_q[0].data);
      chk("rd_ch", rd_if.ch, m_q[0].ch);
      chk("rd_sel", rd_if.sel, m_q[0].sel);
      chk("rd_last", rd_if.last, m_q.size() == 1);
    end
    chk("done", done, m_done);
    chk("timed_out", timed_out, m_to);
  endtask

  task automatic cyc();
    @(negedge clk);
    check_cycle();
    start = 0;
    abort = 0;
    ch_trig_out = trig_rand ? 4'($urandom) : 4'b0;
    case (rdy_mode)
      0: rd_if.ready = 1;
      1: rd_if.ready = ($urandom % 3 != 0);
      2: if (act_log.size() == 1 && hold < 5) begin
           rd_if.ready = 0;
           hold++;
         end else rd_if.ready = 1;
      default: rd_if.ready = 0;
    endcase
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  task automatic wait_phase(input int p, input string nm);
    int k = 0;
    while (m_phase != p && k < 500) begin cyc(); k++; end
    if (m_phase != p) bound_fail(nm);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    do begin cyc(); k++; end while ((m_phase != 0 || busy) && k < 2000);
    if (m_phase != 0 || busy) bound_fail(nm);
    repeat (2) cyc();
  endtask

  task automatic go(input logic [3:0] en, input logic [1:0] ms,
                    input int unsigned tmo);
    cfg_ch_en = en;
    cfg_master = ms;
    cfg_timeout = tmo;
    start = 1;
    act_log.delete();
    done_seen = 0;
    vcnt = 0;
    hold = 0;
  endtask

  task automatic chk_words(input string nm, input int unsigned d[6],
                           input int cnt);
    chk({nm, "_count"}, act_log.size(), cnt);
    for (int k = 0; k < cnt && k < act_log.size(); k++) begin
      chk({nm, "_data"}, act_log[k].data, d[k]);
      chk({nm, "_sel"}, act_log[k].sel, k % 3);
      chk({nm, "_last"}, act_log[k].last, k == cnt - 1);
    end
  endtask

  int unsigned exp_w [6];

  initial begin
    rd_if.ready = 1;
    for (int i = 0; i < N; i++) stop_v[i] = 10;
    repeat (3) cyc();
    chk("rst_busy", busy, 0);
    chk("rst_valid", rd_if.valid, 0);
    chk("rst_en", ch_enable, 0);
    chk("rst_trig", ch_trig_in, 0);
    chk("rst_to", timed_out, 0);
    chk("rst_done", done, 0);
    chk("rst_data", rd_if.data, 0);
    rst_n = 1;
    cyc();
    go(4'b0000, 0, 0);
    repeat (3) cyc();
    chk("zero_en_start_busy", busy, 0);

    // Two channels finishing at d3=7 and d3=9.
    stop_v[0] = 7; stop_v[1] = 9; stop_v[2] = 50; stop_v[3] = 50;
    go(4'b0011, 0, 0);
    wait_idle("t1_idle");
    exp_w = '{14, 21, 7, 18, 28, 9};
    chk_words("t1", exp_w, 6);
    if (act_log.size() == 6) chk("t1_ch1", act_log[4].ch, 1);
    chk("t1_done_cnt", done_seen, 1);
    chk("t1_to", timed_out, 0);

    // Timeout after 100 RUN cycles while d3 keeps counting.
    stop_v[0] = 32'hFFFF_FFFF;
    go(4'b0001, 0, 100);
    wait_idle("t2_idle");
    exp_w = '{202, 303, 101, 0, 0, 0};
    chk_words("t2", exp_w, 3);
    chk("t2_to", timed_out, 1);

    // Trigger broadcast from master 2.
    for (int i = 0; i < N; i++) stop_v[i] = 30;
    cyc();
    ch_trig_out = 4'b0100;
    #1 chk("t3_trig_idle", ch_trig_in, 4'b0000);
    go(4'b1111, 2, 0);
    wait_phase(2, "t3_run");
    ch_trig_out = 4'b0100;
    #1 chk("t3_trig_run", ch_trig_in, 4'b1011);
    wait_phase(4, "t3_read");
    ch_trig_out = 4'b0100;
    #1 chk("t3_trig_read", ch_trig_in, 4'b0000);
    wait_idle("t3_idle");
    chk("t3_to_cleared", timed_out, 0);

    // Backpressure on word 2 plus an ignored mid-run start.
    stop_v[0] = 3; stop_v[1] = 5;
    rdy_mode = 2;
    go(4'b0011, 1, 0);
    wait_phase(2, "t4_run");
    cfg_ch_en = 4'b1111; cfg_master = 3; cfg_timeout = 3;
    start = 1;
    cyc();
    #1 chk("t4_en_kept", ch_enable, 4'b0011);
    wait_idle("t4_idle");
    exp_w = '{6, 9, 3, 10, 16, 5};
    chk_words("t4", exp_w, 6);
    chk("t4_valid_cycles", vcnt, 11);
    chk("t4_to", timed_out, 0);
    rdy_mode = 0;

    // Abort while word 1 is pending; timed_out must survive.
    stop_v[0] = 32'hFFFF_FFFF; stop_v[1] = 32'hFFFF_FFFF;
    rdy_mode = 3;
    go(4'b0011, 0, 20);
    wait_phase(4, "t5_read");
    abort = 1;
    cyc();
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_valid", rd_if.valid, 0);
    chk("t5_en", ch_enable, 0);
    chk("t5_to", timed_out, 1);
    repeat (3) cyc();
    chk("t5_done_cnt", done_seen, 0);
    chk("t5_words", act_log.size(), 0);

    // Reset during readout clears timed_out.
    go(4'b0001, 0, 5);
    wait_phase(4, "t5b_read");
    rst_n = 0;
    #1;
    chk("t5b_to", timed_out, 0);
    chk("t5b_busy", busy, 0);
    chk("t5b_valid", rd_if.valid, 0);
    cyc();
    rst_n = 1;
    cyc();
    rdy_mode = 0;

`ifdef EDGE_SEQ_REARM_EN
    stop_v[0] = 4;
    cfg_rearm = 1;
    go(4'b0001, 0, 0);
    begin
      int k = 0;
      while (!m_done && k < 200) begin cyc(); k++; end
      if (!m_done) bound_fail("t6_done");
    end
    chk("t6_done", done, 1);
    chk("t6_clear_en", ch_enable, 0);
    chk("t6_busy", busy, 1);
    cfg_rearm = 0;
    cyc();
    chk("t6_run_en", ch_enable, 4'b0001);
    wait_idle("t6_idle");
`endif

    // Randomized traffic against the model.
    rdy_mode = 1;
    trig_rand = 1;
    for (int i = 0; i < N; i++) stop_v[i] = $urandom_range(1, 40);
    for (int c = 0; c < 5000; c++) begin
      cyc();
      if ($urandom % 12 == 0) begin
        start = 1;
        cfg_ch_en = 4'($urandom);
        cfg_master = 2'($urandom);
        cfg_timeout = ($urandom % 3 == 0) ? 0 : $urandom_range(1, 60);
      end
      if ($urandom % 200 == 0) abort = 1;
      if ($urandom % 25 == 0) stop_v[$urandom % N] = $urandom_range(1, 50);
`ifdef EDGE_SEQ_REARM_EN
      if ($urandom % 40 == 0) cfg_rearm = ($urandom % 4 == 0);
`endif
    end
`ifdef EDGE_SEQ_REARM_EN
    cfg_rearm = 0;
`endif
    rdy_mode = 0;
    wait_idle("rand_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
